vga_sync_decoder: RTL

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from an incoming VGA hsync/vsync/rgb stream and
// locks once the line and frame timing has been seen clean for LOCK_FRAMES frames.
module vga_sync_decoder #(
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [2:0] rgb,
    output logic [9:0] pixel_row,
    output logic [9:0] pixel_col,
    output logic [2:0] pixel_rgb,
    output logic       pixel_valid,
    output logic       frame_start,
    output logic       locked,
    output logic [7:0] error_count,
    output logic [1:0] lock_state
);

    localparam logic [9:0] H_START_C = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_END_C   = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0] H_LAST_C  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_START_C = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_END_C   = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [9:0] V_LAST_C  = 10'(V_TOTAL - 1);
    localparam logic [7:0] LOCK_C    = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    logic        hs1_q, vs1_q, hs_prev_q, vs_fall_q;
    logic [2:0]  rgb1_q;
    logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    lock_state_t state_q, state_d;
    logic [7:0]  good_q, good_d, err_cnt_q, err_cnt_d;
    logic        hs_fall, fs_det, line_err, timeout_err, frame_err, any_err, vis;

    // h_cnt_d/v_cnt_d are the coordinates of the pixel currently in stage 1,
    // so everything registered from them lands exactly two clocks after the pins.
    always_comb begin
        hs_fall     = hs_prev_q & ~hs1_q;
        fs_det      = hs_fall & vs_fall_q & ~vs1_q;
        h_cnt_d     = hs_fall ? 10'd0 : ((h_cnt_q == 10'h3FF) ? h_cnt_q : h_cnt_q + 10'd1);
        v_cnt_d     = v_cnt_q;
        if (fs_det) begin
            v_cnt_d = 10'd0;
        end else if (hs_fall && v_cnt_q != 10'h3FF) begin
            v_cnt_d = v_cnt_q + 10'd1;
        end
        line_err    = hs_fall & (h_cnt_q != H_LAST_C);
        timeout_err = ~hs_fall & (h_cnt_q == 10'h3FE);
        frame_err   = fs_det & (v_cnt_q != V_LAST_C);
        any_err     = line_err | timeout_err | frame_err;

        state_d   = state_q;
        good_d    = good_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            SEARCH: begin
                if (fs_det) begin
                    state_d = VERIFY;
                    good_d  = 8'd0;
                end
            end
            VERIFY: begin
                if (any_err) begin
                    state_d = SEARCH;
                end else if (fs_det) begin
                    good_d = good_q + 8'd1;
                    if (good_d >= LOCK_C) state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (any_err) begin
                    state_d = SEARCH;
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                end
            end
            default: state_d = SEARCH;
        endcase

        // Valid-only stream: pixel_valid qualifies row/col/rgb; there is no ready.
        vis = (state_d == LOCKED) &&
              (h_cnt_d >= H_START_C) && (h_cnt_d < H_END_C) &&
              (v_cnt_d >= V_START_C) && (v_cnt_d < V_END_C);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs1_q       <= 1'b1;
            vs1_q       <= 1'b1;
            hs_prev_q   <= 1'b1;
            vs_fall_q   <= 1'b1;
            rgb1_q      <= 3'd0;
            h_cnt_q     <= 10'd0;
            v_cnt_q     <= 10'd0;
            state_q     <= SEARCH;
            good_q      <= 8'd0;
            err_cnt_q   <= 8'd0;
            pixel_valid <= 1'b0;
            pixel_row   <= 10'd0;
            pixel_col   <= 10'd0;
            pixel_rgb   <= 3'd0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
        end else begin
            hs1_q       <= hsync;
            vs1_q       <= vsync;
            rgb1_q      <= rgb;
            hs_prev_q   <= hs1_q;
            if (hs_fall) vs_fall_q <= vs1_q;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            state_q     <= state_d;
            good_q      <= good_d;
            err_cnt_q   <= err_cnt_d;
            pixel_valid <= vis;
            pixel_col   <= vis ? (h_cnt_d - H_START_C) : 10'd0;
            pixel_row   <= vis ? (v_cnt_d - V_START_C) : 10'd0;
            pixel_rgb   <= vis ? rgb1_q : 3'd0;
            frame_start <= fs_det;
            locked      <= (state_d == LOCKED);
        end
    end

    assign error_count = err_cnt_q;
    assign lock_state  = state_q;

endmodule
